// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory bus between a fetch port and a data port.
// Round-robin pick with lock-until-grant; an in-order ID FIFO routes responses back.
module mem_port_arbiter #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                             clk_in,
   input  logic                             rst_n_in,
   input  logic                             i_req_in,
   input  logic [ADDR_W-1:0]                i_addr_in,
   output logic                             i_gnt_out,
   output logic                             i_rvalid_out,
   output logic [DATA_W-1:0]                i_rdata_out,
   input  logic                             d_req_in,
   input  logic [ADDR_W-1:0]                d_addr_in,
   input  logic                             d_we_in,
   input  logic [DATA_W/8-1:0]              d_be_in,
   input  logic [DATA_W-1:0]                d_wdata_in,
   output logic                             d_gnt_out,
   output logic                             d_rvalid_out,
   output logic [DATA_W-1:0]                d_rdata_out,
   input  logic                             flush_in,
   output logic                             mem_req_out,
   output logic [ADDR_W-1:0]                mem_addr_out,
   output logic                             mem_we_out,
   output logic [DATA_W/8-1:0]              mem_be_out,
   output logic [DATA_W-1:0]                mem_wdata_out,
   input  logic                             mem_gnt_in,
   input  logic                             mem_rvalid_in,
   input  logic [DATA_W-1:0]                mem_rdata_in,
   output logic [$clog2(DEPTH+1)-1:0]       outstanding_out
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCK_I   = 2'd1,
      ST_LOCK_D   = 2'd2
   } arb_state_t;

   arb_state_t        state_r;
   arb_state_t        state_nxt_s;
   logic              rr_r;
   logic              sel_s;
   logic              sel_req_s;
   logic              full_s;
   logic              accept_s;
   logic              pop_s;
   logic              head_id_s;
   logic              head_drop_s;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [DEPTH-1:0]  fifo_id_r;
   logic [DEPTH-1:0]  fifo_drop_r;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1'b1);
      end
   endfunction

   // Port selection: a locked winner is kept; otherwise rr_r breaks ties (1 = data preferred).
   always_comb begin
      sel_s = 1'b0;
      case (state_r)
         ST_LOCK_I: sel_s = 1'b0;
         ST_LOCK_D: sel_s = 1'b1;
         ST_UNLOCKED: begin
            if (i_req_in && d_req_in) begin
               sel_s = rr_r;
            end else if (d_req_in) begin
               sel_s = 1'b1;
            end else begin
               sel_s = 1'b0;
            end
         end
         default: sel_s = 1'b0;
      endcase
   end

   // Bus drive, grants and response routing; no push/pop bypass at full.
   always_comb begin
      full_s       = (count_r == CNT_W'(DEPTH));
      sel_req_s    = sel_s ? d_req_in : i_req_in;
      mem_req_out  = sel_req_s && !full_s;
      accept_s     = mem_req_out && mem_gnt_in;
      pop_s        = mem_rvalid_in && (count_r != {CNT_W{1'b0}});
      head_id_s    = fifo_id_r[rd_ptr_r];
      head_drop_s  = fifo_drop_r[rd_ptr_r];
      i_gnt_out    = accept_s && !sel_s;
      d_gnt_out    = accept_s && sel_s;
      i_rvalid_out = pop_s && !head_id_s && !head_drop_s;
      d_rvalid_out = pop_s && head_id_s;
      i_rdata_out  = mem_rdata_in;
      d_rdata_out  = mem_rdata_in;
      if (sel_s) begin
         mem_addr_out  = d_addr_in;
         mem_we_out    = d_we_in;
         mem_be_out    = d_be_in;
         mem_wdata_out = d_wdata_in;
      end else begin
         mem_addr_out  = i_addr_in;
         mem_we_out    = 1'b0;
         mem_be_out    = {BE_W{1'b1}};
         mem_wdata_out = {DATA_W{1'b0}};
      end
   end

   // Lock next-state: a stalled request locks its port until that port is granted.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_UNLOCKED: begin
            if (mem_req_out && !mem_gnt_in) begin
               state_nxt_s = sel_s ? ST_LOCK_D : ST_LOCK_I;
            end else begin
               state_nxt_s = ST_UNLOCKED;
            end
         end
         ST_LOCK_I, ST_LOCK_D: begin
            if (accept_s) begin
               state_nxt_s = ST_UNLOCKED;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: state_nxt_s = ST_UNLOCKED;
      endcase
   end

   // Arbitration state and round-robin pointer.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_r <= ST_UNLOCKED;
         rr_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            rr_r <= ~sel_s;
         end
      end
   end

   // ID FIFO; flush marks fetch entries (stale slots too, harmless since a push rewrites drop).
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         fifo_id_r   <= {DEPTH{1'b0}};
         fifo_drop_r <= {DEPTH{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
      end else begin
         if (flush_in) begin
            fifo_drop_r <= fifo_drop_r | ~fifo_id_r;
         end
         if (accept_s) begin
            fifo_id_r[wr_ptr_r]   <= sel_s;
            fifo_drop_r[wr_ptr_r] <= flush_in && !sel_s;
            wr_ptr_r              <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign outstanding_out = count_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_mem_port_arbiter;

   localparam int DEPTH = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;

   logic          clk;
   logic          rst_n;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic [AW-1:0] d_addr;
   logic          d_we;
   logic [BW-1:0] d_be;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          flush;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    outstanding;

   int vectors    = 0;
   int miscompares = 0;

   // reference model: queue of in-flight {port, drop}, lock owner, last granted port
   bit   q_id[$];
   bit   q_drop[$];
   int   lock_port;
   int   last_port;
   logic e_sel, e_mem_req, e_i_gnt, e_d_gnt, e_i_rv, e_d_rv;
   logic [1:0] e_out;

   mem_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_in(clk), .rst_n_in(rst_n),
      .i_req_in(i_req), .i_addr_in(i_addr), .i_gnt_out(i_gnt),
      .i_rvalid_out(i_rvalid), .i_rdata_out(i_rdata),
      .d_req_in(d_req), .d_addr_in(d_addr), .d_we_in(d_we), .d_be_in(d_be),
      .d_wdata_in(d_wdata), .d_gnt_out(d_gnt), .d_rvalid_out(d_rvalid),
      .d_rdata_out(d_rdata), .flush_in(flush),
      .mem_req_out(mem_req), .mem_addr_out(mem_addr), .mem_we_out(mem_we),
      .mem_be_out(mem_be), .mem_wdata_out(mem_wdata), .mem_gnt_in(mem_gnt),
      .mem_rvalid_in(mem_rvalid), .mem_rdata_in(mem_rdata),
      .outstanding_out(outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      q_id.delete();
      q_drop.delete();
      lock_port = -1;
      last_port = 1;
   endtask

   task automatic model_eval();
      bit full;
      bit both;
      full = (q_id.size() >= DEPTH);
      both = i_req && d_req;
      if (lock_port >= 0)  e_sel = (lock_port == 1);
      else if (both)       e_sel = (last_port == 0);
      else                 e_sel = d_req;
      e_mem_req = (e_sel ? d_req : i_req) && !full;
      e_i_gnt   = mem_gnt && e_mem_req && !e_sel;
      e_d_gnt   = mem_gnt && e_mem_req && e_sel;
      e_i_rv    = mem_rvalid && (q_id.size() > 0) && !q_id[0] && !q_drop[0];
      e_d_rv    = mem_rvalid && (q_id.size() > 0) && q_id[0];
      e_out     = 2'(q_id.size());
   endtask

   task automatic model_update();
      bit accept;
      accept = e_mem_req && mem_gnt;
      if (mem_rvalid && q_id.size() > 0) begin
         void'(q_id.pop_front());
         void'(q_drop.pop_front());
      end
      if (flush) begin
         foreach (q_id[k]) if (!q_id[k]) q_drop[k] = 1'b1;
      end
      if (accept) begin
         q_id.push_back(e_sel);
         q_drop.push_back(flush && !e_sel);
         lock_port = -1;
         last_port = e_sel ? 1 : 0;
      end else if (e_mem_req) begin
         lock_port = e_sel ? 1 : 0;
      end
   endtask

   task automatic tick();
      model_eval();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_addr = 32'h0;
      d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0; flush = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      #3;
      vectors++;
      if ({mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, i_gnt, d_gnt, i_rvalid, d_rvalid});
      end
      vectors++;
      if (outstanding !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_outstanding got=%0d exp=0", outstanding);
      end
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fetch_single();
      i_req = 1'b1; i_addr = 32'h0000_1000; mem_gnt = 1'b1;
      #3;
      vectors++;
      if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL fetch_gnt got=i%b d%b req%b exp=i1 d0 req1", i_gnt, d_gnt, mem_req);
      end
      vectors++;
      if (mem_addr !== 32'h0000_1000) begin
         miscompares++;
         $display("FAIL fetch_addr got=%h exp=00001000", mem_addr);
      end
      tick();
      i_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #3;
      vectors++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF || d_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL fetch_resp got=irv%b %h drv%b exp=irv1 deadbeef drv0", i_rvalid, i_rdata, d_rvalid);
      end
      tick();
      mem_rvalid = 1'b0;
      #3;
      vectors++;
      if (outstanding !== 2'd0) begin
         miscompares++;
         $display("FAIL fetch_drain got=%0d exp=0", outstanding);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic prev_sel;
      prev_sel = 1'b0;
      for (int c = 0; c < 6; c++) begin
         i_req = (c < 5); d_req = (c < 5); mem_gnt = (c < 5);
         i_addr = 32'h100 + 32'(c); d_addr = 32'h200 + 32'(c);
         mem_rvalid = (c > 0); mem_rdata = 32'hA000 + 32'(c);
         model_eval();
         #3;
         vectors++;
         if (i_gnt !== e_i_gnt || d_gnt !== e_d_gnt) begin
            miscompares++;
            $display("FAIL b2b_gnt c=%0d got=i%b d%b exp=i%b d%b", c, i_gnt, d_gnt, e_i_gnt, e_d_gnt);
         end
         if (c > 0 && c < 5) begin
            vectors++;
            if (d_gnt !== ~prev_sel) begin
               miscompares++;
               $display("FAIL b2b_alternate c=%0d got=d_gnt%b exp=%b", c, d_gnt, ~prev_sel);
            end
         end
         prev_sel = d_gnt;
         vectors++;
         if (i_rvalid !== e_i_rv || d_rvalid !== e_d_rv || (mem_rvalid && (i_rvalid == d_rvalid))) begin
            miscompares++;
            $display("FAIL b2b_rvalid c=%0d got=i%b d%b exp=i%b d%b", c, i_rvalid, d_rvalid, e_i_rv, e_d_rv);
         end
         tick();
      end
      idle_inputs();
      #3;
      vectors++;
      if (outstanding !== 2'd0) begin
         miscompares++;
         $display("FAIL b2b_drain got=%0d exp=0", outstanding);
      end
      tick();
   endtask

   task automatic test_lock();
      for (int c = 0; c < 5; c++) begin
         d_req = (c < 4); d_addr = 32'hD0D0_0040; d_we = 1'b1; d_be = 4'h3; d_wdata = 32'h5555_AAAA;
         i_req = (c >= 1); i_addr = 32'hF0F0_0080;
         mem_gnt = (c >= 3);
         #3;
         if (c < 4) begin
            vectors++;
            if (mem_addr !== 32'hD0D0_0040 || mem_we !== 1'b1 || mem_req !== 1'b1) begin
               miscompares++;
               $display("FAIL lock_hold c=%0d got=%h we%b req%b exp=d0d00040 we1 req1", c, mem_addr, mem_we, mem_req);
            end
         end
         vectors++;
         if (i_gnt !== (c == 4) || d_gnt !== (c == 3)) begin
            miscompares++;
            $display("FAIL lock_gnt c=%0d got=i%b d%b exp=i%b d%b", c, i_gnt, d_gnt, (c == 4), (c == 3));
         end
         tick();
      end
      idle_inputs();
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      #3;
      vectors++;
      if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL lock_resp_d got=d%b i%b %h exp=d1 i0 12345678", d_rvalid, i_rvalid, d_rdata);
      end
      tick();
      #3;
      vectors++;
      if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL lock_resp_i got=i%b d%b exp=i1 d0", i_rvalid, d_rvalid);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_full();
      i_req = 1'b1; mem_gnt = 1'b1;
      for (int c = 0; c < 2; c++) begin
         i_addr = 32'h300 + 32'(c);
         tick();
      end
      i_addr = 32'h302;
      #3;
      vectors++;
      if (mem_req !== 1'b0 || i_gnt !== 1'b0 || outstanding !== 2'd2) begin
         miscompares++;
         $display("FAIL full_block got=req%b gnt%b occ%0d exp=req0 gnt0 occ2", mem_req, i_gnt, outstanding);
      end
      tick();
      mem_rvalid = 1'b1;
      #3;
      vectors++;
      if (mem_req !== 1'b0 || i_rvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL full_nobypass got=req%b irv%b exp=req0 irv1", mem_req, i_rvalid);
      end
      tick();
      mem_rvalid = 1'b0;
      #3;
      vectors++;
      if (mem_req !== 1'b1 || i_gnt !== 1'b1 || outstanding !== 2'd1) begin
         miscompares++;
         $display("FAIL full_resume got=req%b gnt%b occ%0d exp=req1 gnt1 occ1", mem_req, i_gnt, outstanding);
      end
      tick();
      idle_inputs();
      mem_rvalid = 1'b1;
      tick();
      tick();
      mem_rvalid = 1'b0;
      #3;
      vectors++;
      if (outstanding !== 2'd0) begin
         miscompares++;
         $display("FAIL full_drain got=%0d exp=0", outstanding);
      end
      tick();
   endtask

   task automatic test_flush();
      i_req = 1'b1; mem_gnt = 1'b1; i_addr = 32'h400;
      tick();
      i_addr = 32'h404;
      tick();
      idle_inputs();
      flush = 1'b1;
      #3;
      vectors++;
      if (outstanding !== 2'd2) begin
         miscompares++;
         $display("FAIL flush_occ got=%0d exp=2", outstanding);
      end
      tick();
      flush = 1'b0;
      mem_rvalid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         mem_rdata = 32'hBAD0 + 32'(c);
         #3;
         vectors++;
         if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || outstanding !== 2'(2 - c)) begin
            miscompares++;
            $display("FAIL flush_drop c=%0d got=irv%b drv%b occ%0d exp=irv0 drv0 occ%0d", c, i_rvalid, d_rvalid, outstanding, 2 - c);
         end
         tick();
      end
      mem_rvalid = 1'b0; i_req = 1'b1; mem_gnt = 1'b1; i_addr = 32'h408;
      #3;
      vectors++;
      if (outstanding !== 2'd0 || i_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_refetch got=occ%0d gnt%b exp=occ0 gnt1", outstanding, i_gnt);
      end
      tick();
      idle_inputs();
      mem_rvalid = 1'b1; mem_rdata = 32'hC0DE_0001;
      #3;
      vectors++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'hC0DE_0001) begin
         miscompares++;
         $display("FAIL flush_after got=irv%b %h exp=irv1 c0de0001", i_rvalid, i_rdata);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_addr = 32'h500; mem_gnt = 1'b1;
      tick();
      idle_inputs();
      #1;
      vectors++;
      if (outstanding !== 2'd1) begin
         miscompares++;
         $display("FAIL rstmid_before got=%0d exp=1", outstanding);
      end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (outstanding !== 2'd0 || mem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_async got=occ%0d req%b exp=occ0 req0", outstanding, mem_req);
      end
      #2 rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      tick();
      #3;
      vectors++;
      if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || outstanding !== 2'd0) begin
         miscompares++;
         $display("FAIL rstmid_stray got=d%b i%b occ%0d exp=d0 i0 occ0", d_rvalid, i_rvalid, outstanding);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      logic gi, gd;
      logic [AW-1:0] ea;
      for (int c = 0; c < 600; c++) begin
         if (!i_req && ($urandom % 3 == 0)) begin
            i_req = 1'b1; i_addr = $urandom;
         end
         if (!d_req && ($urandom % 3 == 0)) begin
            d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom);
            d_be = 4'($urandom); d_wdata = $urandom;
         end
         mem_gnt    = ($urandom % 4) != 0;
         mem_rvalid = ($urandom % 3) == 0;
         mem_rdata  = $urandom;
         flush      = ($urandom % 8) == 0;
         model_eval();
         #3;
         vectors++;
         if (mem_req !== e_mem_req || i_gnt !== e_i_gnt || d_gnt !== e_d_gnt) begin
            miscompares++;
            $display("FAIL rnd_arb c=%0d got=req%b i%b d%b exp=req%b i%b d%b", c, mem_req, i_gnt, d_gnt, e_mem_req, e_i_gnt, e_d_gnt);
         end
         vectors++;
         if (i_rvalid !== e_i_rv || d_rvalid !== e_d_rv || outstanding !== e_out) begin
            miscompares++;
            $display("FAIL rnd_resp c=%0d got=i%b d%b occ%0d exp=i%b d%b occ%0d", c, i_rvalid, d_rvalid, outstanding, e_i_rv, e_d_rv, e_out);
         end
         if (e_mem_req) begin
            ea = e_sel ? d_addr : i_addr;
            vectors++;
            if (mem_addr !== ea || mem_we !== (e_sel ? d_we : 1'b0) || (e_sel && (mem_be !== d_be || mem_wdata !== d_wdata))) begin
               miscompares++;
               $display("FAIL rnd_bus c=%0d got=%h we%b be%h exp=%h sel%b", c, mem_addr, mem_we, mem_be, ea, e_sel);
            end
         end
         if (e_i_rv || e_d_rv) begin
            vectors++;
            if ((e_i_rv && i_rdata !== mem_rdata) || (e_d_rv && d_rdata !== mem_rdata)) begin
               miscompares++;
               $display("FAIL rnd_rdata c=%0d got=i%h d%h exp=%h", c, i_rdata, d_rdata, mem_rdata);
            end
         end
         gi = e_i_gnt;
         gd = e_d_gnt;
         tick();
         if (gi) i_req = 1'b0;
         if (gd) d_req = 1'b0;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch_single();
      test_back_to_back();
      test_lock();
      test_full();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
